// File: rtl/ublock_ti_pkg.sv
// Shared constants and FSM encoding for the two-share uBlock S-box layer scheduler.
package ublock_ti_pkg;
  localparam int NIBBLES_DEF  = 32;
  localparam int SBOX_LAT_DEF = 2;
  localparam int IDX_W_DEF    = $clog2(NIBBLES_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  // Nibble-index width, kept at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nibble_valid_pipe.sv
// Delay line carrying the fed nibble index alongside the S-box pipeline latency.
module nibble_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int IW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_vld,
  input  logic [IW-1:0] i_idx,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);
  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_vld = i_vld;
      assign o_idx = i_idx;
    end else begin : g_pipe
      logic [DEPTH-1:0]         r_vld_pipe;
      logic [DEPTH-1:0][IW-1:0] r_idx_pipe;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_vld_pipe <= '0;
          r_idx_pipe <= '0;
        end else begin
          r_vld_pipe[0] <= i_vld;
          r_idx_pipe[0] <= i_idx;
          for (int s = 1; s < DEPTH; s++) begin
            r_vld_pipe[s] <= r_vld_pipe[s-1];
            r_idx_pipe[s] <= r_idx_pipe[s-1];
          end
        end
      end

      assign o_vld = r_vld_pipe[DEPTH-1];
      assign o_idx = r_idx_pipe[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/sbox_layer_scheduler.sv
// Streams one nibble pair per cycle through an external shared S-box and
// reassembles both output shares, pulsing done when the layer is complete.
module sbox_layer_scheduler
  import ublock_ti_pkg::*;
#(
  parameter int NIBBLES  = NIBBLES_DEF,
  parameter int SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_s0_i,
  input  logic [4*NIBBLES-1:0] state_s1_i,
  input  logic [3:0]           rnd_i,
  output logic                 rnd_req,
  output logic [3:0]           sb_d0c0b0a0,
  output logic [3:0]           sb_d1c1b1a1,
  output logic [3:0]           sb_guards,
  input  logic [3:0]           sb_h0g0f0e0,
  input  logic [3:0]           sb_h1g1f1e1,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] state_s0_o,
  output logic [4*NIBBLES-1:0] state_s1_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  fsm_e          r_state;
  logic [IW-1:0] r_cnt;
  logic [W-1:0]  r_s0, r_s1;
  logic [W-1:0]  r_s0_o, r_s1_o;
  logic          r_done;

  logic          w_feed;
  logic          w_vld;
  logic [IW-1:0] w_idx;

  assign w_feed = (r_state == FEED);

  // Share paths stay separate: share k of the state only ever reaches port k.
  assign sb_d0c0b0a0 = w_feed ? r_s0[{r_cnt, 2'b00} +: 4] : 4'h0;
  assign sb_d1c1b1a1 = w_feed ? r_s1[{r_cnt, 2'b00} +: 4] : 4'h0;
  assign sb_guards   = w_feed ? rnd_i : 4'h0;
  assign rnd_req     = w_feed;

  assign busy       = (r_state != IDLE) || r_done;
  assign done       = r_done;
  assign state_s0_o = r_s0_o;
  assign state_s1_o = r_s1_o;

  nibble_valid_pipe #(
    .DEPTH(SBOX_LAT),
    .IW   (IW)
  ) u_vpipe (
    .clk  (clk),
    .rstn (rstn),
    .i_vld(w_feed),
    .i_idx(r_cnt),
    .o_vld(w_vld),
    .o_idx(w_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FEED;
            r_cnt   <= '0;
            r_s0    <= state_s0_i;
            r_s1    <= state_s1_i;
          end
        end
        FEED: begin
          if (r_cnt == LAST) r_state <= DRAIN;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        DRAIN:   ;
        default: r_state <= IDLE;
      endcase
      // Completion keys off the last write, which also covers zero latency.
      if (w_vld && (w_idx == LAST)) begin
        r_state <= IDLE;
        r_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s0_o <= '0;
      r_s1_o <= '0;
    end else if (w_vld) begin
      r_s0_o[{w_idx, 2'b00} +: 4] <= sb_h0g0f0e0;
      r_s1_o[{w_idx, 2'b00} +: 4] <= sb_h1g1f1e1;
    end
  end
endmodule

// File: tb/tb_sbox_layer_scheduler.sv
// Randomized bench for sbox_layer_scheduler with a switchable loopback / masked S-box stub.
module tb_sbox_layer_scheduler;
  localparam int N   = 32;
  localparam int LAT = 2;
  localparam int W   = 4 * N;
  localparam int TOT = N + LAT + 1;

  logic         clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [W-1:0] state_s0_i = '0, state_s1_i = '0;
  logic [3:0]   rnd_i = 4'h0;
  logic         rnd_req, busy, done;
  logic [3:0]   sb_d0, sb_d1, sb_g, sb_h0, sb_h1;
  logic [W-1:0] state_s0_o, state_s1_o;
  logic         use_sbox = 1'b0;

  int n_vec = 0, n_err = 0;
  int cnt_busy, cnt_req;
  bit saw_done;
  logic [W-1:0] cap_s0, cap_s1;

  always #5 clk = ~clk;

  sbox_layer_scheduler #(.NIBBLES(N), .SBOX_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .state_s0_i(state_s0_i), .state_s1_i(state_s1_i),
    .rnd_i(rnd_i), .rnd_req(rnd_req),
    .sb_d0c0b0a0(sb_d0), .sb_d1c1b1a1(sb_d1), .sb_guards(sb_g),
    .sb_h0g0f0e0(sb_h0), .sb_h1g1f1e1(sb_h1),
    .busy(busy), .done(done),
    .state_s0_o(state_s0_o), .state_s1_o(state_s1_o)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'h7; 4'h1: return 4'h4; 4'h2: return 4'h9; 4'h3: return 4'hC;
      4'h4: return 4'hB; 4'h5: return 4'hA; 4'h6: return 4'hD; 4'h7: return 4'h8;
      4'h8: return 4'hF; 4'h9: return 4'hE; 4'hA: return 4'h1; 4'hB: return 4'h6;
      4'hC: return 4'h0; 4'hD: return 4'h3; 4'hE: return 4'h2; default: return 4'h5;
    endcase
  endfunction

  function automatic logic [W-1:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // S-box stub: LAT register stages; masked mode yields out0^out1 = S(in0^in1).
  logic [3:0] w_in0, w_in1;
  logic [3:0] q0 [1:LAT];
  logic [3:0] q1 [1:LAT];
  always_comb begin
    w_in0 = use_sbox ? (sb(sb_d0 ^ sb_d1) ^ sb_g) : sb_d0;
    w_in1 = use_sbox ? sb_g : sb_d1;
  end
  always @(posedge clk) begin
    q0[1] <= w_in0;
    q1[1] <= w_in1;
    for (int s = 2; s <= LAT; s++) begin
      q0[s] <= q0[s-1];
      q1[s] <= q1[s-1];
    end
  end
  assign sb_h0 = q0[LAT];
  assign sb_h1 = q1[LAT];

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_i = 4'($urandom);
    end
  end

  // Reference model: m_c is the cycle number since the accepting edge (0 = idle).
  int           m_c = 0;
  logic [W-1:0] m_s0 = '0, m_s1 = '0, m_res0 = '0, m_res1 = '0;
  logic [3:0]   m_g [N];
  logic         m_mode = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_c    <= 0;
      m_res0 <= '0;
      m_res1 <= '0;
    end else begin
      if (m_c >= 1 && m_c <= N) m_g[m_c-1] <= rnd_i;
      if (m_c == 0 || m_c == TOT) begin
        if (start) begin
          m_c    <= 1;
          m_s0   <= state_s0_i;
          m_s1   <= state_s1_i;
          m_mode <= use_sbox;
        end else begin
          m_c <= 0;
        end
      end else begin
        m_c <= m_c + 1;
      end
      if (m_c == TOT - 1) begin
        for (int k = 0; k < N; k++) begin
          m_res0[4*k +: 4] <= m_mode ? (sb(m_s0[4*k +: 4] ^ m_s1[4*k +: 4]) ^ m_g[k]) : m_s0[4*k +: 4];
          m_res1[4*k +: 4] <= m_mode ? m_g[k] : m_s1[4*k +: 4];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare();
    logic       feed;
    logic [3:0] e_d0, e_d1, e_g;
    feed = (m_c >= 1 && m_c <= N);
    e_d0 = 4'h0; e_d1 = 4'h0; e_g = 4'h0;
    if (feed) begin
      e_d0 = m_s0[4*(m_c-1) +: 4];
      e_d1 = m_s1[4*(m_c-1) +: 4];
      e_g  = rnd_i;
    end
    chk("busy",    busy,    (m_c != 0));
    chk("done",    done,    (m_c == TOT));
    chk("rnd_req", rnd_req, feed);
    chk("guards",  sb_g,    e_g);
    chk("sb_d0",   sb_d0,   e_d0);
    chk("sb_d1",   sb_d1,   e_d1);
    if (m_c == 0 || m_c == TOT) begin
      chk("s0_o", state_s0_o, m_res0);
      chk("s1_o", state_s1_o, m_res1);
    end
  endtask

  // One clock: check at the falling edge, then move just past the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    if (busy)    cnt_busy++;
    if (rnd_req) cnt_req++;
    if (done) begin
      saw_done = 1'b1;
      cap_s0   = state_s0_o;
      cap_s1   = state_s1_o;
    end
    @(posedge clk); #1;
  endtask

  task automatic begin_layer(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    state_s0_i = a;
    state_s1_i = b;
    start      = 1'b1;
    tick();
    start      = keep;
    state_s0_i = r128();
    state_s1_i = r128();
  endtask

  task automatic wait_done(input int pulse_at, output int n);
    cnt_busy = 0; cnt_req = 0; saw_done = 1'b0; n = 0;
    while (!saw_done && n < 200) begin
      tick();
      n++;
      if (n == pulse_at) start = 1'b1;
      else if (pulse_at >= 0 && n == pulse_at + 1) start = 1'b0;
    end
  endtask

  localparam logic [W-1:0] LIT0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [W-1:0] XPAT = 128'hFEDCBA9876543210_FEDCBA9876543210;
  localparam logic [W-1:0] SPAT = 128'h523061EF8DABC947_523061EF8DABC947;

  initial begin
    int n;
    logic [W-1:0] s1;

    repeat (2) tick();
    chk("rst_s0o",  state_s0_o, '0);
    chk("rst_busy", busy, '0);
    chk("rst_sb",   {sb_d0, sb_d1, sb_g, rnd_req}, '0);
    rstn = 1'b1;
    repeat (2) tick();

    use_sbox = 1'b0;
    begin_layer(LIT0, '0, 1'b0);
    wait_done(-1, n);
    chk("lb_len",  n,        TOT);
    chk("lb_busy", cnt_busy, TOT);
    chk("lb_req",  cnt_req,  N);
    chk("lb_s0o",  cap_s0,   LIT0);
    chk("lb_s1o",  cap_s1,   '0);
    repeat (2) tick();

    use_sbox = 1'b1;
    s1 = r128();
    begin_layer(XPAT ^ s1, s1, 1'b0);
    wait_done(-1, n);
    chk("sb_len", n, TOT);
    chk("sb_xor", cap_s0 ^ cap_s1, SPAT);
    tick();

    begin_layer(r128(), r128(), 1'b0);
    repeat (9) tick();
    rstn = 1'b0;
    tick();
    chk("abort_s0o",  state_s0_o, '0);
    chk("abort_s1o",  state_s1_o, '0);
    chk("abort_busy", {busy, done, rnd_req}, '0);
    rstn = 1'b1;
    tick();
    s1 = r128();
    begin_layer(XPAT ^ s1, s1, 1'b0);
    wait_done(-1, n);
    chk("post_rst_len", n, TOT);
    chk("post_rst_xor", cap_s0 ^ cap_s1, SPAT);
    tick();

    begin_layer(r128(), r128(), 1'b0);
    wait_done(4, n);
    chk("pulse_len", n, TOT);
    repeat (3) tick();

    begin_layer(r128(), r128(), 1'b1);
    wait_done(-1, n);
    chk("hold_len1", n, TOT);
    start = 1'b0;
    wait_done(-1, n);
    chk("hold_len2", n, TOT);
    repeat (2) tick();

    for (int it = 0; it < 8; it++) begin
      use_sbox = 1'($urandom_range(0, 1));
      begin_layer(r128(), r128(), 1'b0);
      wait_done(-1, n);
      chk("rnd_len", n, TOT);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sbox_layer_scheduler.md
Name: sbox_layer_scheduler

Overview:
- Sequences one S-box layer of the 128-bit two-share uBlock state through a single external `shared_sbox` instance, one nibble per cycle.
- Latches both input shares, streams nibble pairs into the S-box and supplies fresh guards each fed cycle.
- Aligns returning outputs to the S-box pipeline latency and reassembles both output shares, then pulses `done`.
- Sits between the round controller and the `shared_sbox` datapath.

Parameters:
- NIBBLES, 32, nibbles per state (state width = 4*NIBBLES).
- SBOX_LAT, 2, register stages inside `shared_sbox` (input cycle to output cycle); 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin layer; sampled only in IDLE.
- state_s0_i  in  4*NIBBLES  input share 0.
- state_s1_i  in  4*NIBBLES  input share 1.
- rnd_i  in  4  fresh randomness; a new value is required every cycle `rnd_req` is high.
- rnd_req  out  1  high in cycles where `rnd_i` is consumed.
- sb_d0c0b0a0  out  4  to `shared_sbox` share-0 input.
- sb_d1c1b1a1  out  4  to `shared_sbox` share-1 input.
- sb_guards  out  4  to `shared_sbox` guards.
- sb_h0g0f0e0  in  4  from `shared_sbox` share-0 output.
- sb_h1g1f1e1  in  4  from `shared_sbox` share-1 output.
- busy  out  1  layer in progress.
- done  out  1  one-cycle completion pulse.
- state_s0_o  out  4*NIBBLES  result share 0.
- state_s1_o  out  4*NIBBLES  result share 1.

Behaviour:
Reset (async, rstn=0):
- FSM=IDLE; all counters, the valid pipe, latched shares and result registers cleared.
- `busy`, `done`, `rnd_req` = 0; all `sb_*` outputs = 0; `state_s*_o` = 0.

FSM IDLE -> FEED -> DRAIN -> IDLE:
- Let E0 be the edge at which start=1 is sampled in IDLE. At E0, both shares are latched and the feed counter is set to 0. `busy` is high from the cycle after E0 through the `done` cycle.
- FEED: in the cycle after edge E_k (k = 0..NIBBLES-1), `sb_d0c0b0a0` = s0[4k+3:4k], `sb_d1c1b1a1` = s1[4k+3:4k], `sb_guards` = `rnd_i` (combinational), `rnd_req` = 1. After the nibble NIBBLES-1 cycle the FSM goes to DRAIN. If SBOX_LAT=0 it goes directly to the completion step.
- Outside FEED: `sb_*` outputs = 0 and `rnd_req` = 0. A new share value is never driven while guards are zero in FEED.
- Valid pipe: a SBOX_LAT-deep shift register carries the fed nibble index. The output for nibble k is present in the cycle after E_{k+SBOX_LAT} and is written at E_{k+SBOX_LAT+1} into `state_s0_o`/`state_s1_o` bits [4k+3:4k].
- The last write is at E_{NIBBLES+SBOX_LAT}. `done` = 1 for exactly the following cycle; the FSM returns to IDLE in that same cycle, so a start sampled during the `done` cycle is accepted.
- Total: NIBBLES+SBOX_LAT+1 cycles from E0 to the `done` cycle. For defaults that is 35.

Results:
- `state_s*_o` change only at nibble-write edges.
- They are stable from `done` until the next start's first write. During `busy` they hold mixed old/new nibbles and are not valid.

Boundary conditions:
- start while busy: ignored; no restart.
- start held high: one layer per IDLE visit.
- Input state changes after E0: no effect.
- Reset mid-layer: immediate abort to reset values. No `done` is generated and no partial result is retained.
- Counter width: $clog2(NIBBLES). The feed counter stops at NIBBLES-1 and never wraps to 0 during a layer.
- Shares are never combined inside this block. Per nibble, only share k of the state and share k of the S-box output meet share k's path.

Decomposition:
- Package `ublock_ti_pkg`: NIBBLES, SBOX_LAT defaults, FSM state encoding (IDLE, FEED, DRAIN), nibble-index width constant.
- `shared_sbox` is instantiated by the parent, not inside this block.
- No internal sub-module is required. The valid/index delay line may be a small sub-module `nibble_valid_pipe`.

Test Plan:
- Loopback stub (SBOX_LAT-stage register, out = in): s0=0x0123456789ABCDEF_FEDCBA9876543210, s1=0, start at E0 -> `done` in cycle 35, s0_o = s0, s1_o = 0, `busy` high for 35 cycles, `rnd_req` high for exactly 32.
- Real `shared_sbox`, random s1, s0 = X^s1 with X=0x00..0F repeated (nibble k = k mod 16), random `rnd_i` each cycle -> s0_o^s1_o equals the golden uBlock S-box table applied per nibble.
- Reset asserted in cycle 10 of a layer -> all outputs 0 immediately; a subsequent start produces a correct layer with identical timing.
- start pulsed at cycle 5 of a layer -> ignored, single `done` at cycle 35. start during the `done` cycle -> second layer begins, second `done` 35 cycles later.
- Monitor `sb_guards` == `rnd_i` while `rnd_req`=1 and == 0 otherwise. All `sb_*` outputs are 0 in IDLE.
- Parameter sweep SBOX_LAT=0 and 3 with loopback stub -> `done` at NIBBLES+SBOX_LAT+1 cycles after E0, correct nibble order.
